// File: rtl/axi4_burst_pkg.sv
// Shared types and address helpers for the AXI4 burst RAM slave.
package axi4_burst_pkg;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_BURST} rstate_t;

  // Addresses are carried at a fixed internal width so the helpers stay parameter-free.
  localparam int AMAX = 32;
  typedef logic [AMAX-1:0] addr_t;

  function automatic addr_t next_addr(addr_t addr, logic [2:0] size, logic [7:0] len, logic [1:0] burst);
    addr_t step, wmask;
    step  = addr_t'(1) << size;
    wmask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    case (burst)
      INCR:    next_addr = addr + step;
      WRAP:    next_addr = (addr & ~wmask) | ((addr + step) & wmask);
      default: next_addr = addr;
    endcase
  endfunction

  function automatic logic burst_err(addr_t addr, logic [2:0] size, logic [7:0] len,
                                     logic [1:0] burst, logic [2:0] max_size);
    addr_t last;
    logic  wrap_len;
    last     = addr + ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    wrap_len = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    burst_err = (size > max_size) || (burst == 2'b11) ||
                (burst == WRAP && !wrap_len) ||
                (burst == WRAP && ((addr & ((addr_t'(1) << size) - addr_t'(1))) != '0)) ||
                (burst == INCR && (last[AMAX-1:12] != addr[AMAX-1:12]));
  endfunction
endpackage

// File: rtl/axi4_burst_slave_if.sv
// AXI4 five-channel bundle between an interconnect master and the RAM slave.
interface axi4_burst_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID, AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST, WVALID, WREADY;
  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID, BREADY;
  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID, ARREADY;
  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST, RVALID, RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
           ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
           ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi4_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port (read-old on collision).
module axi4_sdp_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [$clog2(MEMORY_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH/8-1:0]         wstrb,
  input  logic                            re,
  input  logic [$clog2(MEMORY_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]           rdata
);
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
  end
endmodule

// File: rtl/axi4_burst_slave.sv
// AXI4 RAM slave: independent write and read burst engines over a dual-port RAM.
module axi4_burst_slave
  import axi4_burst_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 4,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi4_burst_slave_if.slave bus
);
  localparam int SHIFT = $clog2(DATA_WIDTH/8);
  localparam int RAW   = $clog2(MEMORY_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(SHIFT);

  // ---------------- write engine ----------------
  wstate_t             w_state;
  logic                awready, wready, bvalid;
  logic [1:0]          bresp;
  logic [ID_WIDTH-1:0] bid;
  addr_t               w_addr, w_idx;
  logic [7:0]          w_len, w_cnt;
  logic [2:0]          w_size;
  logic [1:0]          w_burst;
  logic                w_berr, w_err, w_ok, w_fire, w_last, wlast_bad, ram_we;

  assign w_idx     = w_addr >> SHIFT;
  assign w_ok      = ~w_berr & (w_idx < addr_t'(MEMORY_DEPTH));
  assign w_fire    = wready & bus.WVALID;
  assign w_last    = (w_cnt == w_len);
  assign wlast_bad = (bus.WLAST != w_last);
  assign ram_we    = w_fire & w_ok;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE; awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
      bresp <= OKAY; bid <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0;
      w_size <= '0; w_burst <= '0; w_berr <= 1'b0; w_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awready && bus.AWVALID) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= bus.AWID;
            w_addr  <= addr_t'(bus.AWADDR[ADDR_WIDTH-1:0]);
            w_len   <= bus.AWLEN;
            w_size  <= bus.AWSIZE;
            w_burst <= bus.AWBURST;
            w_cnt   <= '0;
            w_berr  <= burst_err(addr_t'(bus.AWADDR), bus.AWSIZE, bus.AWLEN, bus.AWBURST, MAX_SIZE);
            w_err   <= burst_err(addr_t'(bus.AWADDR), bus.AWSIZE, bus.AWLEN, bus.AWBURST, MAX_SIZE);
            w_state <= W_DATA;
          end
        end
        W_DATA: if (w_fire) begin
          w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
          w_cnt  <= w_cnt + 8'd1;
          w_err  <= w_err | ~w_ok | wlast_bad;
          // Beat count alone ends the burst; a WLAST disagreement only taints BRESP.
          if (w_last) begin
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= (w_err | ~w_ok | wlast_bad) ? SLVERR : OKAY;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (bus.BREADY) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read engine ----------------
  rstate_t               r_state;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  addr_t                 r_addr, r_idx;
  logic [7:0]            r_len, r_icnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_berr, r_idone;
  // Two-entry output buffer: s1 lives in the RAM read register, skid holds the older beat.
  logic                  s1_valid, s1_last, s1_err;
  logic                  skid_valid, skid_last, skid_err;
  logic [DATA_WIDTH-1:0] skid_data, ram_q, head_data;
  logic                  rvalid, head_last, head_err, r_fire, s1_keep, skid_keep;
  logic                  issue, rd_err, rd_last;

  assign rvalid    = skid_valid | s1_valid;
  assign head_last = skid_valid ? skid_last : s1_last;
  assign head_err  = skid_valid ? skid_err  : s1_err;
  assign head_data = skid_valid ? skid_data : ram_q;
  assign r_fire    = rvalid & bus.RREADY;
  assign s1_keep   = s1_valid & ~(r_fire & ~skid_valid);
  assign skid_keep = skid_valid & ~r_fire;
  assign issue     = (r_state == R_BURST) & ~r_idone & ~(s1_keep & skid_keep);
  assign r_idx     = r_addr >> SHIFT;
  assign rd_err    = r_berr | (r_idx >= addr_t'(MEMORY_DEPTH));
  assign rd_last   = (r_icnt == r_len);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE; arready <= 1'b0; rid <= '0; r_addr <= '0; r_len <= '0;
      r_icnt <= '0; r_size <= '0; r_burst <= '0; r_berr <= 1'b0; r_idone <= 1'b0;
      s1_valid <= 1'b0; s1_last <= 1'b0; s1_err <= 1'b0;
      skid_valid <= 1'b0; skid_last <= 1'b0; skid_err <= 1'b0; skid_data <= '0;
    end else begin
      s1_valid   <= s1_keep;
      skid_valid <= skid_keep;
      if (issue) begin
        s1_valid <= 1'b1;
        s1_last  <= rd_last;
        s1_err   <= rd_err;
        r_addr   <= next_addr(r_addr, r_size, r_len, r_burst);
        r_icnt   <= r_icnt + 8'd1;
        if (rd_last) r_idone <= 1'b1;
        // The RAM register is about to be overwritten: park its unconsumed beat.
        if (s1_keep) begin
          skid_valid <= 1'b1;
          skid_data  <= ram_q;
          skid_last  <= s1_last;
          skid_err   <= s1_err;
        end
      end
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arready && bus.ARVALID) begin
            arready <= 1'b0;
            rid     <= bus.ARID;
            r_addr  <= addr_t'(bus.ARADDR[ADDR_WIDTH-1:0]);
            r_len   <= bus.ARLEN;
            r_size  <= bus.ARSIZE;
            r_burst <= bus.ARBURST;
            r_berr  <= burst_err(addr_t'(bus.ARADDR), bus.ARSIZE, bus.ARLEN, bus.ARBURST, MAX_SIZE);
            r_icnt  <= '0;
            r_idone <= 1'b0;
            r_state <= R_BURST;
          end
        end
        R_BURST: if (r_fire && head_last) begin
          arready <= 1'b1;
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi4_sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .MEMORY_DEPTH(MEMORY_DEPTH)) u_ram (
    .clk(ACLK), .we(ram_we), .waddr(w_idx[RAW-1:0]), .wdata(bus.WDATA), .wstrb(bus.WSTRB),
    .re(issue), .raddr(r_idx[RAW-1:0]), .rdata(ram_q)
  );

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.BID     = bid;
  assign bus.ARREADY = arready;
  assign bus.RID     = rid;
  assign bus.RVALID  = rvalid;
  assign bus.RDATA   = (rvalid & ~head_err) ? head_data : '0;
  assign bus.RRESP   = (rvalid & head_err) ? SLVERR : OKAY;
  assign bus.RLAST   = rvalid & head_last;
endmodule
